// File: rtl/univ_shift_reg.sv
// Universal WIDTH-bit shift register: hold, shift, rotate, load and clear, with a word-complete pulse.
// Optional feature macro USR_ARITH_SHIFT_EN turns mode 7 into an arithmetic shift right.
module univ_shift_reg #(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clk_en,
    input  logic [2:0]       mode,
    input  logic             sin_msb,
    input  logic             sin_lsb,
    input  logic [WIDTH-1:0] load_data,
    output logic [WIDTH-1:0] q,
    output logic             sout_lsb,
    output logic             sout_msb,
    output logic [CW-1:0]    count,
    output logic             word_done
);

    typedef enum logic [2:0] {
        MODE_HOLD  = 3'd0,
        MODE_SHR   = 3'd1,
        MODE_SHL   = 3'd2,
        MODE_ROR   = 3'd3,
        MODE_ROL   = 3'd4,
        MODE_LOAD  = 3'd5,
        MODE_CLEAR = 3'd6,
        MODE_ASR   = 3'd7
    } modeOp_e;

    modeOp_e          modeSel;
    logic [WIDTH-1:0] shiftReg_q, shiftReg_d;
    logic [CW-1:0]    count_q, count_d;
    logic             wordDone_q, wordDone_d;
    logic             isShift;
    logic             restartCount;

    assign modeSel = modeOp_e'(mode);

    always_comb begin
        shiftReg_d   = shiftReg_q;
        isShift      = 1'b0;
        restartCount = 1'b0;
        if (clk_en) begin
            case (modeSel)
                MODE_SHR: begin
                    shiftReg_d = {sin_msb, shiftReg_q[WIDTH-1:1]};
                    isShift    = 1'b1;
                end
                MODE_SHL: begin
                    shiftReg_d = {shiftReg_q[WIDTH-2:0], sin_lsb};
                    isShift    = 1'b1;
                end
                MODE_ROR: begin
                    shiftReg_d = {shiftReg_q[0], shiftReg_q[WIDTH-1:1]};
                    isShift    = 1'b1;
                end
                MODE_ROL: begin
                    shiftReg_d = {shiftReg_q[WIDTH-2:0], shiftReg_q[WIDTH-1]};
                    isShift    = 1'b1;
                end
                MODE_LOAD: begin
                    shiftReg_d   = load_data;
                    restartCount = 1'b1;
                end
                MODE_CLEAR: begin
                    shiftReg_d   = '0;
                    restartCount = 1'b1;
                end
`ifdef USR_ARITH_SHIFT_EN
                MODE_ASR: begin
                    shiftReg_d = {shiftReg_q[WIDTH-1], shiftReg_q[WIDTH-1:1]};
                    isShift    = 1'b1;
                end
`endif
                default: begin
                    shiftReg_d = shiftReg_q;
                end
            endcase
        end
    end

    // The pulse request defaults low, so word_done self-clears even while clk_en is low.
    always_comb begin
        count_d    = count_q;
        wordDone_d = 1'b0;
        if (restartCount) begin
            count_d = '0;
        end else if (isShift) begin
            if (count_q == CW'(WIDTH - 1)) begin
                count_d    = '0;
                wordDone_d = 1'b1;
            end else begin
                count_d = count_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            shiftReg_q <= '0;
            count_q    <= '0;
            wordDone_q <= 1'b0;
        end else begin
            shiftReg_q <= shiftReg_d;
            count_q    <= count_d;
            wordDone_q <= wordDone_d;
        end
    end

    assign q         = shiftReg_q;
    assign sout_lsb  = shiftReg_q[0];
    assign sout_msb  = shiftReg_q[WIDTH-1];
    assign count     = count_q;
    assign word_done = wordDone_q;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Bench for univ_shift_reg (WIDTH=8): arithmetic reference model checked every cycle plus literal vectors.
// Honours USR_ARITH_SHIFT_EN the same way the design does.
module tb_univ_shift_reg;

    logic       clk;
    logic       reset;
    logic       clk_en;
    logic [2:0] mode;
    logic       sin_msb;
    logic       sin_lsb;
    logic [7:0] load_data;
    logic [7:0] q;
    logic       sout_lsb;
    logic       sout_msb;
    logic [2:0] count;
    logic       word_done;

    univ_shift_reg #(.WIDTH(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .clk_en    (clk_en),
        .mode      (mode),
        .sin_msb   (sin_msb),
        .sin_lsb   (sin_lsb),
        .load_data (load_data),
        .q         (q),
        .sout_lsb  (sout_lsb),
        .sout_msb  (sout_msb),
        .count     (count),
        .word_done (word_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: value as a byte, count as total shifts since restart taken modulo 8.
    logic [7:0] modelQ, nextQ;
    int         modelShifts, nextShifts;
    logic       modelDone, nextDone;
    logic       didShift;
    logic       modelValid;

    always_comb begin
        nextQ      = modelQ;
        nextShifts = modelShifts;
        nextDone   = 1'b0;
        didShift   = 1'b0;
        if (clk_en) begin
            case (mode)
                3'd1: begin
                    nextQ    = (modelQ >> 1) | (sin_msb ? 8'h80 : 8'h00);
                    didShift = 1'b1;
                end
                3'd2: begin
                    nextQ    = (modelQ << 1) | (sin_lsb ? 8'h01 : 8'h00);
                    didShift = 1'b1;
                end
                3'd3: begin
                    nextQ    = (modelQ >> 1) | (((modelQ & 8'h01) != 0) ? 8'h80 : 8'h00);
                    didShift = 1'b1;
                end
                3'd4: begin
                    nextQ    = (modelQ << 1) | (((modelQ & 8'h80) != 0) ? 8'h01 : 8'h00);
                    didShift = 1'b1;
                end
                3'd5: begin
                    nextQ      = load_data;
                    nextShifts = 0;
                end
                3'd6: begin
                    nextQ      = 8'h00;
                    nextShifts = 0;
                end
`ifdef USR_ARITH_SHIFT_EN
                3'd7: begin
                    nextQ    = (modelQ >> 1) | (modelQ & 8'h80);
                    didShift = 1'b1;
                end
`endif
                default: begin
                    nextQ = modelQ;
                end
            endcase
            if (didShift) begin
                nextShifts = modelShifts + 1;
                nextDone   = ((nextShifts % 8) == 0);
            end
        end
    end

    always @(posedge clk) begin
        if (!reset) begin
            modelQ      <= 8'h00;
            modelShifts <= 0;
            modelDone   <= 1'b0;
            modelValid  <= 1'b1;
        end else begin
            modelQ      <= nextQ;
            modelShifts <= nextShifts;
            modelDone   <= nextDone;
        end
    end

    initial modelValid = 1'b0;

    // Per-cycle comparison against the model on the falling edge.
    int cmpChecks = 0;
    int cmpFails  = 0;

    initial begin
        logic [31:0] act [5];
        logic [31:0] exp [5];
        string       nm  [5];
        nm[0] = "model_q";
        nm[1] = "model_count";
        nm[2] = "model_word_done";
        nm[3] = "model_sout_lsb";
        nm[4] = "model_sout_msb";
        forever begin
            @(negedge clk);
            if (modelValid) begin
                act[0] = 32'(q);
                exp[0] = 32'(modelQ);
                act[1] = 32'(count);
                exp[1] = 32'(modelShifts % 8);
                act[2] = 32'(word_done);
                exp[2] = 32'(modelDone);
                act[3] = 32'(sout_lsb);
                exp[3] = 32'(modelQ & 8'h01);
                act[4] = 32'(sout_msb);
                exp[4] = 32'((modelQ >> 7) & 8'h01);
                for (int k = 0; k < 5; k++) begin
                    cmpChecks++;
                    if (act[k] !== exp[k]) begin
                        cmpFails++;
                        $display("[TB] FAIL %s at %0t: got %0h, expected %0h", nm[k], $time, act[k], exp[k]);
                    end
                end
            end
        end
    end

    int litChecks = 0;
    int litFails  = 0;

    task automatic applyStimulus(input logic rstN, input logic en, input logic [2:0] m,
                                 input logic sm, input logic sl, input logic [7:0] ld);
        @(negedge clk);
        reset     = rstN;
        clk_en    = en;
        mode      = m;
        sin_msb   = sm;
        sin_lsb   = sl;
        load_data = ld;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        litChecks++;
        if (actual !== expected) begin
            litFails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    initial begin
        reset     = 1'b0;
        clk_en    = 1'b0;
        mode      = 3'd5;
        sin_msb   = 1'b0;
        sin_lsb   = 1'b0;
        load_data = 8'hFF;

        // Reset beats an enabled load.
        applyStimulus(1'b0, 1'b1, 3'd5, 1'b0, 1'b0, 8'hFF);
        applyStimulus(1'b0, 1'b1, 3'd5, 1'b0, 1'b0, 8'hFF);
        checkOutput("reset_q", 32'(q), 32'h00);
        checkOutput("reset_count", 32'(count), 0);
        checkOutput("reset_word_done", 32'(word_done), 0);

        applyStimulus(1'b1, 1'b1, 3'd5, 1'b0, 1'b0, 8'hA5);
        checkOutput("load_a5", 32'(q), 32'hA5);
        applyStimulus(1'b1, 1'b1, 3'd1, 1'b1, 1'b0, 8'h00);
        checkOutput("shr1_q", 32'(q), 32'hD2);
        checkOutput("shr1_sout_lsb", 32'(sout_lsb), 0);
        applyStimulus(1'b1, 1'b1, 3'd1, 1'b0, 1'b0, 8'h00);
        checkOutput("shr2_q", 32'(q), 32'h69);
        checkOutput("shr2_count", 32'(count), 2);

        $display("[TB] rotate-left word");
        applyStimulus(1'b1, 1'b1, 3'd5, 1'b0, 1'b0, 8'h81);
        checkOutput("rol_load_count", 32'(count), 0);
        for (int i = 1; i <= 8; i++) begin
            applyStimulus(1'b1, 1'b1, 3'd4, 1'b0, 1'b0, 8'h00);
            checkOutput("rol_count", 32'(count), 32'(i % 8));
            checkOutput("rol_word_done", 32'(word_done), 32'(i == 8));
        end
        checkOutput("rol_q", 32'(q), 32'h81);
        applyStimulus(1'b1, 1'b1, 3'd0, 1'b0, 1'b0, 8'h00);
        checkOutput("hold_pulse_cleared", 32'(word_done), 0);

        applyStimulus(1'b1, 1'b1, 3'd5, 1'b0, 1'b0, 8'h01);
        applyStimulus(1'b1, 1'b1, 3'd3, 1'b0, 1'b0, 8'h00);
        checkOutput("ror_q", 32'(q), 32'h80);
        checkOutput("ror_sout_msb", 32'(sout_msb), 1);

        $display("[TB] clk_en gap");
        applyStimulus(1'b1, 1'b1, 3'd5, 1'b0, 1'b0, 8'h0F);
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(1'b1, 1'b1, 3'd2, 1'b0, 1'b1, 8'h00);
            checkOutput("gap_pre_count", 32'(count), 32'(i));
        end
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b0, 3'd2, 1'b0, 1'b1, 8'h00);
            checkOutput("gap_frozen_count", 32'(count), 4);
            checkOutput("gap_word_done", 32'(word_done), 0);
        end
        for (int i = 5; i <= 8; i++) begin
            applyStimulus(1'b1, 1'b1, 3'd2, 1'b0, 1'b1, 8'h00);
            checkOutput("gap_post_word_done", 32'(word_done), 32'(i == 8));
        end
        checkOutput("gap_q", 32'(q), 32'hFF);
        applyStimulus(1'b1, 1'b0, 3'd2, 1'b0, 1'b1, 8'h00);
        checkOutput("gap_pulse_clears_disabled", 32'(word_done), 0);

        $display("[TB] mid-word restart");
        for (int i = 1; i <= 5; i++) begin
            applyStimulus(1'b1, 1'b1, 3'd1, 1'b0, 1'b0, 8'h00);
            checkOutput("mid_pre_word_done", 32'(word_done), 0);
        end
        checkOutput("mid_pre_count", 32'(count), 5);
        applyStimulus(1'b1, 1'b1, 3'd5, 1'b0, 1'b0, 8'h3C);
        checkOutput("mid_load_count", 32'(count), 0);
        for (int i = 1; i <= 8; i++) begin
            applyStimulus(1'b1, 1'b1, 3'd1, 1'b0, 1'b0, 8'h00);
            checkOutput("mid_word_done", 32'(word_done), 32'(i == 8));
        end
        checkOutput("mid_q", 32'(q), 32'h00);

        applyStimulus(1'b1, 1'b1, 3'd5, 1'b0, 1'b0, 8'h5A);
        applyStimulus(1'b1, 1'b1, 3'd1, 1'b1, 1'b0, 8'h00);
        applyStimulus(1'b1, 1'b1, 3'd6, 1'b0, 1'b0, 8'h00);
        checkOutput("clear_q", 32'(q), 32'h00);
        checkOutput("clear_count", 32'(count), 0);

        applyStimulus(1'b1, 1'b1, 3'd2, 1'b0, 1'b1, 8'h00);
        applyStimulus(1'b1, 1'b1, 3'd2, 1'b0, 1'b1, 8'h00);
        applyStimulus(1'b0, 1'b1, 3'd2, 1'b0, 1'b1, 8'h00);
        checkOutput("midword_reset_count", 32'(count), 0);
        checkOutput("midword_reset_q", 32'(q), 32'h00);

        applyStimulus(1'b1, 1'b1, 3'd5, 1'b0, 1'b0, 8'h90);
        applyStimulus(1'b1, 1'b1, 3'd7, 1'b0, 1'b0, 8'h00);
`ifdef USR_ARITH_SHIFT_EN
        checkOutput("mode7_q", 32'(q), 32'hC8);
        checkOutput("mode7_count", 32'(count), 1);
`else
        checkOutput("mode7_q", 32'(q), 32'h90);
        checkOutput("mode7_count", 32'(count), 0);
`endif

        applyStimulus(1'b1, 1'b1, 3'd0, 1'b0, 1'b0, 8'h00);
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", (litChecks + cmpChecks) - (litFails + cmpFails), litChecks + cmpChecks);
        $finish;
    end

endmodule
